snake_grid_engine: RTL and testbench

Parametrised grid-based snake game core. It replaces the free-pixel, twist-list snake with a cell-grid model. The body is a circular buffer of cell coordinates, and the block adds food, growth, score, self/wall collision and a restart command. It sits between the UART receive path (byte strobe) and the VGA pixel pipeline (pixel query in, layer flags out). The colour mux lives downstream.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_lfsr.sv | 19 +
 rtl/snake_grid_engine.sv | 201 ++++++++++++++++++++
 tb/tb_snake_grid_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and command codes for the grid snake engine.
package snake_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'b00,
    LEFT  = 2'b01,
    UP    = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    FOOD,
    OVER
  } state_t;

  localparam logic [7:0] CMD_UP      = 8'd65;
  localparam logic [7:0] CMD_DOWN    = 8'd66;
  localparam logic [7:0] CMD_RIGHT   = 8'd67;
  localparam logic [7:0] CMD_LEFT    = 8'd68;
  localparam logic [7:0] CMD_RESTART = 8'd82;

  // Opposite directions share the axis bit and differ in the sense bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) used to place food.
module snake_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (load) begin
      value <= SEED;
    end else if (advance) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/snake_grid_engine.sv
// Grid snake core: circular body buffer, food placement, collisions, score
// and a registered per-pixel layer query for the video pipeline.
module snake_grid_engine
  import snake_pkg::*;
#(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int CELL_LOG2   = 4,
  parameter int MAX_LEN     = 64,
  parameter int INIT_LEN    = 4,
  parameter int STEP_FRAMES = 8,
  parameter int INIT_X      = 20,
  parameter int INIT_Y      = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  input  logic [7:0]                cmd_data,
  input  logic                      frame_tick,
  input  logic [9:0]                x_px,
  input  logic [9:0]                y_px,
  input  logic                      activevideo,
  output logic                      pix_body,
  output logic                      pix_head,
  output logic                      pix_food,
  output logic                      pix_wall,
  output logic                      game_over,
  output logic [15:0]               score,
  output logic [$clog2(MAX_LEN):0]  length
);

  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = $clog2(GRID_H);
  localparam int C_W = X_W + Y_W;
  localparam int P_W = $clog2(MAX_LEN);
  localparam int L_W = P_W + 1;
  localparam int T_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  state_t state, state_nx, ret_state;
  dir_t   cur_dir, pending_dir, cmd_dir, dir_ref;

  logic [C_W-1:0] body [MAX_LEN];
  logic [C_W-1:0] food;
  logic [P_W-1:0] head_ptr, tail_ptr;
  logic [T_W-1:0] tick_cnt;
  logic [15:0]    lfsr;

  logic [X_W-1:0] head_x, nx_x, cand_x;
  logic [Y_W-1:0] head_y, nx_y, cand_y;
  logic [9:0]     cell_x, cell_y;
  logic [C_W-1:0] px_cell;

  logic init, cmd_is_dir, cmd_accept, step_due, counting;
  logic wall_hit, self_hit, eat, cand_on_body, cand_ok;
  logic px_in_grid, px_body_hit;
  logic unused_lfsr;

  assign init = rst || (state == OVER && cmd_valid && cmd_data == CMD_RESTART);

  snake_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .load    (init),
    .advance (state == FOOD),
    .value   (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:C_W];
  assign cand_x      = lfsr[X_W-1:0];
  assign cand_y      = lfsr[C_W-1:X_W];

  assign {head_y, head_x} = body[head_ptr];
  assign tail_ptr         = head_ptr - P_W'(length - 1'b1);
  assign game_over        = (state == OVER);

  always_comb begin
    cmd_is_dir = 1'b1;
    cmd_dir    = RIGHT;
    unique case (cmd_data)
      CMD_UP:    cmd_dir = UP;
      CMD_DOWN:  cmd_dir = DOWN;
      CMD_RIGHT: cmd_dir = RIGHT;
      CMD_LEFT:  cmd_dir = LEFT;
      default:   cmd_is_dir = 1'b0;
    endcase
  end

  // On the STEP cycle pending_dir is the move being executed, so a reverse of it is dropped.
  assign dir_ref    = (state == STEP) ? pending_dir : cur_dir;
  assign cmd_accept = cmd_valid && cmd_is_dir && (state != OVER) && !is_reverse(cmd_dir, dir_ref);
  assign step_due   = (state == RUN) && frame_tick && (tick_cnt == T_W'(STEP_FRAMES - 1));
  assign counting   = (state == RUN) || (state == STEP) || (state == FOOD);

  always_comb begin
    nx_x     = head_x;
    nx_y     = head_y;
    wall_hit = 1'b0;
    unique case (pending_dir)
      RIGHT: begin nx_x = head_x + 1'b1; wall_hit = (head_x == X_W'(GRID_W - 1)); end
      LEFT:  begin nx_x = head_x - 1'b1; wall_hit = (head_x == '0); end
      UP:    begin nx_y = head_y - 1'b1; wall_hit = (head_y == '0); end
      DOWN:  begin nx_y = head_y + 1'b1; wall_hit = (head_y == Y_W'(GRID_H - 1)); end
    endcase
  end

  assign eat = ({nx_y, nx_x} == food);

  assign cell_x     = x_px >> CELL_LOG2;
  assign cell_y     = y_px >> CELL_LOG2;
  assign px_in_grid = (32'(cell_x) < GRID_W) && (32'(cell_y) < GRID_H);
  assign px_cell    = {cell_y[Y_W-1:0], cell_x[X_W-1:0]};

  // An entry is live when its distance behind the head is below length.
  always_comb begin
    self_hit     = 1'b0;
    cand_on_body = 1'b0;
    px_body_hit  = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ({1'b0, P_W'(head_ptr - P_W'(i))} < length) begin
        if (body[i] == {nx_y, nx_x} && !(P_W'(i) == tail_ptr && !eat)) self_hit = 1'b1;
        if (body[i] == {cand_y, cand_x}) cand_on_body = 1'b1;
        if (body[i] == px_cell) px_body_hit = 1'b1;
      end
    end
  end

  assign cand_ok = (32'(cand_x) < GRID_W) && (32'(cand_y) < GRID_H) && !cand_on_body;

  always_ff @(posedge clk) begin
    if (init) state <= FOOD;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cmd_accept) state_nx = RUN;
      RUN:  if (step_due) state_nx = STEP;
      STEP: begin
        if (wall_hit || self_hit) state_nx = OVER;
        else if (eat)             state_nx = FOOD;
        else                      state_nx = RUN;
      end
      FOOD: if (cand_ok) state_nx = ret_state;
      OVER: state_nx = OVER;
      default: state_nx = FOOD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      ret_state   <= IDLE;
      cur_dir     <= RIGHT;
      pending_dir <= RIGHT;
      head_ptr    <= P_W'(INIT_LEN - 1);
      length      <= L_W'(INIT_LEN);
      score       <= '0;
      tick_cnt    <= '0;
      food        <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        body[i] <= (i < INIT_LEN) ? {Y_W'(INIT_Y), X_W'(INIT_X + i - (INIT_LEN - 1))} : '0;
      end
    end else begin
      if (cmd_accept) pending_dir <= cmd_dir;

      if (counting && frame_tick) begin
        if (step_due) tick_cnt <= '0;
        else if (tick_cnt != T_W'(STEP_FRAMES - 1)) tick_cnt <= tick_cnt + 1'b1;
      end

      // Tail drop is implicit: tail_ptr follows head_ptr when length holds.
      if (state == STEP && !wall_hit && !self_hit) begin
        head_ptr                 <= head_ptr + 1'b1;
        body[head_ptr + 1'b1]    <= {nx_y, nx_x};
        cur_dir                  <= pending_dir;
        if (eat) begin
          ret_state <= RUN;
          if (score != 16'hFFFF) score <= score + 1'b1;
          if (length != L_W'(MAX_LEN)) length <= length + 1'b1;
        end
      end

      if (state == FOOD && cand_ok) food <= {cand_y, cand_x};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_body <= 1'b0;
      pix_head <= 1'b0;
      pix_food <= 1'b0;
      pix_wall <= 1'b0;
    end else begin
      pix_wall <= activevideo && !px_in_grid;
      pix_body <= activevideo && px_in_grid && px_body_hit;
      pix_head <= activevideo && px_in_grid && (px_cell == body[head_ptr]);
      pix_food <= activevideo && px_in_grid && (px_cell == food);
    end
  end

endmodule

// File: tb/tb_snake_grid_engine.sv
// Directed bench: default-seed instance plus one whose seed puts the first food at (22,15).
module tb_snake_grid_engine;
  import snake_pkg::*;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, frame_tick = 1'b0, activevideo = 1'b0;
  logic [7:0] cmd_data = '0;
  logic [9:0] x_px = '0, y_px = '0;

  logic pix_body, pix_head, pix_food, pix_wall, game_over;
  logic [15:0] score;
  logic [6:0]  length;
  logic f_pix_body, f_pix_head, f_pix_food, f_pix_wall, f_game_over;
  logic [15:0] f_score;
  logic [6:0]  f_length;

  int checks = 0;
  int failures = 0;

  snake_grid_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .frame_tick(frame_tick),
    .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
    .pix_body(pix_body), .pix_head(pix_head), .pix_food(pix_food), .pix_wall(pix_wall),
    .game_over(game_over), .score(score), .length(length)
  );

  snake_grid_engine #(.LFSR_SEED(16'h03D6)) dut_f (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .frame_tick(frame_tick),
    .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
    .pix_body(f_pix_body), .pix_head(f_pix_head), .pix_food(f_pix_food), .pix_wall(f_pix_wall),
    .game_over(f_game_over), .score(f_score), .length(f_length)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmd(input logic [7:0] c);
    cmd_valid = 1'b1; cmd_data = c; cyc(1);
    cmd_valid = 1'b0; cmd_data = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(2); end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(3);
  endtask

  task automatic query(input int cx, input int cy);
    x_px = 10'(cx * 16 + 8); y_px = 10'(cy * 16 + 8); activevideo = 1'b1; cyc(1);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic test_reset();
    rst = 1'b1; x_px = 10'd328; y_px = 10'd248; activevideo = 1'b1; cyc(1);
    checks++; if ({pix_body, pix_head, pix_food, pix_wall} !== 4'b0) begin failures++; $display("FAIL reset_pix: got %b expected 0000", {pix_body, pix_head, pix_food, pix_wall}); end
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_over: got %b expected 0", game_over); end
    checks++; if (score !== 16'd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (length !== 7'd4) begin failures++; $display("FAIL reset_len: got %0d expected 4", length); end
    rst = 1'b0; cyc(3);
    query(20, 15);
    checks++; if ({pix_head, pix_body} !== 2'b11) begin failures++; $display("FAIL reset_head: got %b expected 11", {pix_head, pix_body}); end
    query(17, 15);
    checks++; if ({pix_head, pix_body} !== 2'b01) begin failures++; $display("FAIL reset_tail: got %b expected 01", {pix_head, pix_body}); end
    query(16, 15);
    checks++; if (pix_body !== 1'b0) begin failures++; $display("FAIL reset_past_tail: got %b expected 0", pix_body); end
    query(33, 19);
    checks++; if (pix_food !== 1'b1) begin failures++; $display("FAIL reset_food: got %b expected 1", pix_food); end
    query(40, 3);
    checks++; if (pix_wall !== 1'b1) begin failures++; $display("FAIL wall_pixel: got %b expected 1", pix_wall); end
    x_px = 10'd328; y_px = 10'd248; activevideo = 1'b0; cyc(1);
    checks++; if ({pix_body, pix_head} !== 2'b00) begin failures++; $display("FAIL blank_gate: got %b expected 00", {pix_body, pix_head}); end
  endtask

  task automatic test_step();
    do_reset(); cmd(CMD_RIGHT); ticks(8);
    query(21, 15);
    checks++; if (pix_head !== 1'b1) begin failures++; $display("FAIL step_head: got %b expected 1", pix_head); end
    query(17, 15);
    checks++; if (pix_body !== 1'b0) begin failures++; $display("FAIL step_tail_left: got %b expected 0", pix_body); end
    query(18, 15);
    checks++; if (pix_body !== 1'b1) begin failures++; $display("FAIL step_tail: got %b expected 1", pix_body); end
    checks++; if (length !== 7'd4) begin failures++; $display("FAIL step_len: got %0d expected 4", length); end
  endtask

  task automatic test_food();
    logic [15:0] s;
    int fx, fy;
    do_reset();
    query(22, 15);
    checks++; if (f_pix_food !== 1'b1) begin failures++; $display("FAIL food_seeded: got %b expected 1", f_pix_food); end
    cmd(CMD_RIGHT); ticks(16);
    checks++; if (f_score !== 16'd1) begin failures++; $display("FAIL food_score: got %0d expected 1", f_score); end
    checks++; if (f_length !== 7'd5) begin failures++; $display("FAIL food_len: got %0d expected 5", f_length); end
    cyc(60);
    s = lfsr_next(16'h03D6);
    fx = 0; fy = 0;
    for (int k = 0; k < 2000; k++) begin
      fx = int'(s[5:0]); fy = int'(s[10:6]);
      if (fx < 40 && fy < 30 && !(fy == 15 && fx >= 18 && fx <= 22)) break;
      s = lfsr_next(s);
    end
    query(fx, fy);
    checks++; if (f_pix_food !== 1'b1) begin failures++; $display("FAIL food_replaced at %0d,%0d: got %b expected 1", fx, fy, f_pix_food); end
    query(22, 15);
    checks++; if ({f_pix_head, f_pix_food} !== 2'b10) begin failures++; $display("FAIL food_eaten_cell: got %b expected 10", {f_pix_head, f_pix_food}); end
    query(18, 15);
    checks++; if (f_pix_body !== 1'b1) begin failures++; $display("FAIL food_grown_tail: got %b expected 1", f_pix_body); end
    ticks(8);
    query(18, 15);
    checks++; if (f_pix_body !== 1'b0) begin failures++; $display("FAIL food_tail_after: got %b expected 0", f_pix_body); end
    checks++; if (f_length !== 7'd5) begin failures++; $display("FAIL food_len_hold: got %0d expected 5", f_length); end
  endtask

  task automatic test_direction();
    do_reset(); cmd(CMD_RIGHT); cmd(CMD_LEFT); ticks(8);
    query(21, 15);
    checks++; if (pix_head !== 1'b1) begin failures++; $display("FAIL lone_reverse: got %b expected 1", pix_head); end
    cmd(CMD_LEFT); cmd(CMD_UP); ticks(8);
    query(21, 14);
    checks++; if (pix_head !== 1'b1) begin failures++; $display("FAIL last_cmd_wins: got %b expected 1", pix_head); end
    cmd(CMD_DOWN); ticks(8);
    query(21, 13);
    checks++; if (pix_head !== 1'b1) begin failures++; $display("FAIL reverse_up: got %b expected 1", pix_head); end
  endtask

  task automatic test_wall_restart();
    do_reset(); cmd(CMD_RIGHT); ticks(19 * 8);
    query(39, 15);
    checks++; if ({pix_head, game_over} !== 2'b10) begin failures++; $display("FAIL wall_edge: got %b expected 10", {pix_head, game_over}); end
    ticks(7);
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL over_early: got %b expected 0", game_over); end
    cyc(1);
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL over_rise: got %b expected 1", game_over); end
    ticks(8);
    query(39, 15);
    checks++; if (pix_head !== 1'b1) begin failures++; $display("FAIL over_frozen: got %b expected 1", pix_head); end
    checks++; if (f_score !== 16'd1 || f_game_over !== 1'b1) begin failures++; $display("FAIL over_f: score %0d over %b expected 1 1", f_score, f_game_over); end
    cmd(CMD_RIGHT);
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL over_ignore_cmd: got %b expected 1", game_over); end
    cmd(CMD_RESTART);
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL restart_over: got %b expected 0", game_over); end
    cyc(3);
    query(20, 15);
    checks++; if (pix_head !== 1'b1) begin failures++; $display("FAIL restart_head: got %b expected 1", pix_head); end
    checks++; if (f_score !== 16'd0) begin failures++; $display("FAIL restart_score: got %0d expected 0", f_score); end
    checks++; if (f_length !== 7'd4) begin failures++; $display("FAIL restart_len: got %0d expected 4", f_length); end
  endtask

  task automatic test_self_hit();
    do_reset(); cmd(CMD_RIGHT); ticks(16); cyc(60);
    cmd(CMD_UP); ticks(8); cmd(CMD_LEFT); ticks(8); cmd(CMD_DOWN); ticks(8);
    checks++; if (f_game_over !== 1'b1) begin failures++; $display("FAIL self_hit_len5: got %b expected 1", f_game_over); end
    do_reset(); cmd(CMD_RIGHT); ticks(8);
    cmd(CMD_UP); ticks(8); cmd(CMD_LEFT); ticks(8); cmd(CMD_DOWN); ticks(8);
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL tail_chase: got %b expected 0", game_over); end
    query(20, 15);
    checks++; if (pix_head !== 1'b1) begin failures++; $display("FAIL tail_chase_head: got %b expected 1", pix_head); end
    query(19, 15);
    checks++; if (pix_body !== 1'b0) begin failures++; $display("FAIL tail_chase_body: got %b expected 0", pix_body); end
  endtask

  task automatic test_reset_in_food();
    do_reset(); cmd(CMD_RIGHT); ticks(16);
    x_px = 10'd360; y_px = 10'd248; activevideo = 1'b1;
    rst = 1'b1; cyc(1);
    checks++; if ({f_pix_body, f_pix_head, f_pix_food, f_pix_wall, f_game_over} !== 5'b0) begin failures++; $display("FAIL rst_food_pix: got %b expected 00000", {f_pix_body, f_pix_head, f_pix_food, f_pix_wall, f_game_over}); end
    checks++; if (f_score !== 16'd0 || f_length !== 7'd4) begin failures++; $display("FAIL rst_food_regs: score %0d len %0d expected 0 4", f_score, f_length); end
    rst = 1'b0; cyc(3);
    query(22, 15);
    checks++; if (f_pix_food !== 1'b1) begin failures++; $display("FAIL rst_food_seed: got %b expected 1", f_pix_food); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_food();
    test_direction();
    test_wall_restart();
    test_self_hit();
    test_reset_in_food();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
